prog_loader: RTL

Sequential program loader: receives a framed byte stream over a valid/ready handshake and writes it into program memory, holding the CPU in reset while loading. Sits beside the datapath, between the debug/serial front end and the memory block's external write port, and its CPU-hold output is OR-ed into the datapath reset. The loader owns the memory write port only while `o_cpuHold` is high.

---
 rtl/prog_loader_pkg.sv | 28 ++
 rtl/prog_loader_wrseq.sv | 48 ++++
 rtl/prog_loader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned WR_CYCLES         = 3;

    // Frame-level states of the loader.
    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_e;

    // Write strobe sequencer states (setup / pulse / hold around one write).
    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } wr_state_e;

endpackage

// File: rtl/prog_loader_wrseq.sv
// Three-phase write strobe sequencer: setup (NWE=1), pulse (NWE=0), hold (NWE=1).
module prog_loader_wrseq
    import prog_loader_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_start,
    output logic o_busy,
    output logic o_finished_c,
    output logic o_nwe
);

    wr_state_e state_q, state_d;
    logic      nwe_q, nwe_d;
    logic      busy_q, busy_d;

    // State and registered strobe; reset forces the strobe inactive on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= WR_IDLE;
            nwe_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nwe_q   <= nwe_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state sequencing; strobe and busy are decoded from the next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WR_IDLE:  if (i_start) state_d = WR_SETUP;
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: state_d = WR_HOLD;
            WR_HOLD:  state_d = WR_IDLE;
            default:  state_d = WR_IDLE;
        endcase
        nwe_d  = (state_d != WR_PULSE);
        busy_d = (state_d != WR_IDLE);
    end

    assign o_busy       = busy_q;
    assign o_nwe        = nwe_q;
    assign o_finished_c = (state_q == WR_HOLD);

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader; holds the CPU in reset while writing program memory.
// Optional trailing checksum byte and sticky error flag: define PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [7:0]        i_rxData,
    input  logic              i_rxValid,
    output logic              o_rxReady,
    output logic [ADDR_W-1:0] o_progAddr,
    output logic [7:0]        o_progData,
    output logic              o_progNWE,
    output logic              o_cpuHold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_e S_TAIL = S_CHECK;
`else
    localparam state_e S_TAIL = S_DONE;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [15:0]       len_q, len_d;
    logic              hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rx_ready_q, rx_ready_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              error_q, error_d;
`endif

    logic accept_c;
    logic wr_start_c;
    logic wr_busy;
    logic wr_finished_c;

    // A byte moves only when offered and accepted; never while a write is in flight.
    assign accept_c = i_rxValid && rx_ready_q && !wr_busy;

    prog_loader_wrseq u_wrseq (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (wr_start_c),
        .o_busy       (wr_busy),
        .o_finished_c (wr_finished_c),
        .o_nwe        (o_progNWE)
    );

    // Frame state and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            len_q      <= '0;
            hold_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_ready_q <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            len_q      <= len_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rx_ready_q <= rx_ready_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            error_q    <= error_d;
`endif
        end
    end

    // Frame parsing, write sequencing and output decode from the next state.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        len_d      = len_q;
        hold_d     = hold_q;
        wr_start_c = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        error_d    = error_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept_c && (i_rxData == SYNC_BYTE)) begin
                    state_d = S_ADDR_HI;
                    hold_d  = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d   = '0;
                    error_d = 1'b0;
`endif
                end
            end
            S_ADDR_HI: begin
                if (accept_c) begin
                    addr_d  = {i_rxData, addr_q[7:0]};
                    state_d = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (accept_c) begin
                    addr_d  = {addr_q[15:8], i_rxData};
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept_c) begin
                    len_d   = {i_rxData, len_q[7:0]};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept_c) begin
                    len_d   = {len_q[15:8], i_rxData};
                    state_d = (len_d == 16'd0) ? S_TAIL : S_DATA;
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    data_d     = i_rxData;
                    wr_start_c = 1'b1;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_finished_c) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    len_d   = len_q - 16'd1;
                    state_d = (len_q == 16'd1) ? S_TAIL : S_DATA;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept_c) begin
                    if (i_rxData == sum_q) begin
                        state_d = S_DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef PROG_LOADER_CHECKSUM_EN
        // Running sum covers header and data bytes, not SYNC or the checksum itself.
        if (accept_c && (state_q inside {S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_DATA})) begin
            sum_d = sum_q + i_rxData;
        end
`endif

        if (state_d == S_DONE) begin
            hold_d = 1'b0;
        end
        done_d     = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE);
        rx_ready_d = (state_d inside {S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO,
                                      S_DATA, S_CHECK});
    end

    assign o_rxReady  = rx_ready_q;
    assign o_progAddr = addr_q;
    assign o_progData = data_q;
    assign o_cpuHold  = hold_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign o_error    = error_q;
`else
    assign o_error    = 1'b0;
`endif

endmodule
